uart_tx_sched: RTL and testbench



---
 rtl/uart_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/uart_tx_sched.sv | 137 +++++++++++++
 tb/tb_uart_tx_sched.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_pkg;

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } state_e;

    localparam int unsigned UART_DATA_W      = 8;
    localparam int unsigned UART_FRAME_TICKS = 10;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requester after last_grant_i
// (wrapping) wins.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDW   = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDW-1:0]   last_grant_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDW-1:0]   grant_idx_o,
    output logic             any_grant_o
);

    int unsigned cand;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_grant_o = 1'b0;
        cand        = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = (32'(last_grant_i) + k) % N_REQ;
            if (!any_grant_o && req_i[IDW'(cand)]) begin
                any_grant_o              = 1'b1;
                grant_o[IDW'(cand)]      = 1'b1;
                grant_idx_o              = IDW'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one uart_tx among N_REQ byte requesters: round-robin arbitration,
// burst locking, launch on baud_tick and a watchdog on tx_done.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ         = 4,
    parameter int unsigned TIMEOUT_TICKS = 16,
    parameter int unsigned IDW           = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         baud_tick,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [UART_DATA_W*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]             req_last,
    output logic [N_REQ-1:0]             req_ready,
    output logic                         tx_start,
    output logic [UART_DATA_W-1:0]       tx_data,
    input  logic                         tx_done,
    output logic [IDW-1:0]               grant_id,
    output logic                         busy,
    output logic                         timeout_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_TICKS + 1);

    state_e                 state_q;
    logic [IDW-1:0]         last_grant_q;
    logic [IDW-1:0]         grant_id_q;
    logic                   lock_q;
    logic                   last_latched_q;
    logic [CNT_W-1:0]       tick_cnt_q;
    logic                   tx_start_q;
    logic [UART_DATA_W-1:0] tx_data_q;
    logic                   busy_q;
    logic                   timeout_err_q;

    logic [N_REQ-1:0]       rr_grant_c;
    logic [IDW-1:0]         rr_idx_c;
    logic                   rr_any_c;
    logic                   lock_hit_c;
    logic                   win_any_c;
    logic [IDW-1:0]         win_idx_c;
    logic [N_REQ-1:0]       win_oh_c;
    logic [UART_DATA_W-1:0] win_data_c;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_rr_arbiter (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (rr_grant_c),
        .grant_idx_o  (rr_idx_c),
        .any_grant_o  (rr_any_c)
    );

    // A locked owner that is still valid bypasses the round-robin pick.
    assign lock_hit_c = lock_q && req_valid[grant_id_q];
    assign win_any_c  = lock_hit_c || rr_any_c;
    assign win_idx_c  = lock_hit_c ? grant_id_q : rr_idx_c;
    assign win_oh_c   = lock_hit_c ? (N_REQ'(1) << grant_id_q) : rr_grant_c;
    assign req_ready  = (state_q == ARB) ? win_oh_c : '0;

    always_comb begin
        win_data_c = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (win_idx_c == IDW'(i)) begin
                win_data_c = req_data[UART_DATA_W*i +: UART_DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ARB;
            last_grant_q   <= IDW'(N_REQ - 1);
            grant_id_q     <= '0;
            lock_q         <= 1'b0;
            last_latched_q <= 1'b0;
            tick_cnt_q     <= '0;
            tx_start_q     <= 1'b0;
            tx_data_q      <= '0;
            busy_q         <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            timeout_err_q <= 1'b0;
            case (state_q)
                ARB: begin
                    if (lock_q && !req_valid[grant_id_q]) begin
                        lock_q <= 1'b0;
                    end
                    if (win_any_c) begin
                        tx_data_q      <= win_data_c;
                        grant_id_q     <= win_idx_c;
                        last_latched_q <= req_last[win_idx_c];
                        tx_start_q     <= 1'b1;
                        busy_q         <= 1'b1;
                        state_q        <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (baud_tick) begin
                        tx_start_q <= 1'b0;
                        tick_cnt_q <= '0;
                        state_q    <= WAIT;
                    end
                end
                WAIT: begin
                    // tx_done has priority over a watchdog expiry in the same cycle.
                    if (tx_done) begin
                        last_grant_q <= grant_id_q;
                        lock_q       <= ~last_latched_q;
                        busy_q       <= 1'b0;
                        state_q      <= ARB;
                    end else if (baud_tick && tick_cnt_q == CNT_W'(TIMEOUT_TICKS - 1)) begin
                        timeout_err_q <= 1'b1;
                        last_grant_q  <= grant_id_q;
                        lock_q        <= 1'b0;
                        busy_q        <= 1'b0;
                        state_q       <= ARB;
                    end else if (baud_tick) begin
                        tick_cnt_q <= tick_cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end

    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign grant_id    = grant_id_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: directed vector table, timeout and
// reset sequences, then randomized traffic against a transaction-level model.
module tb_uart_tx_sched;
    import uart_pkg::*;

    logic        clk;
    logic        rst;
    logic        baud_tick;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic [1:0]  grant_id;
    logic        busy;
    logic        timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx_sched #(
        .N_REQ         (4),
        .TIMEOUT_TICKS (16),
        .IDW           (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .baud_tick   (baud_tick),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] data;
        logic [3:0]  exp_oh;
        logic [1:0]  exp_id;
        logic [7:0]  exp_byte;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } item_t;

    vec_t  tbl [12];
    item_t q [4][$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the accept pulse, check it, and cross the accept edge.
    task automatic wait_accept(input logic [3:0] exp_oh, input string nm);
        int n;
        n = 0;
        #1;
        while (req_ready == 4'b0 && n < 20) begin
            step();
            #1;
            n++;
        end
        chk({nm, "_ready"}, 32'(req_ready), 32'(exp_oh));
        step();
        req_valid = req_valid & ~exp_oh;
    endtask

    // Drive one frame: a held tx_start, the launch tick, then either a nominal
    // completion or a silent uart_tx that trips the watchdog.
    task automatic do_frame(input bit with_done, input string nm);
        int n;
        n = with_done ? int'(UART_FRAME_TICKS) : 16;
        chk({nm, "_start"}, 32'(tx_start), 32'd1);
        chk({nm, "_busy"}, 32'(busy), 32'd1);
        baud_tick = 1'b0;
        step();
        chk({nm, "_hold"}, 32'(tx_start), 32'd1);
        baud_tick = 1'b1;
        step();
        baud_tick = 1'b0;
        chk({nm, "_drop"}, 32'(tx_start), 32'd0);
        for (int k = 1; k <= n; k++) begin
            step();
            baud_tick = 1'b1;
            step();
            baud_tick = 1'b0;
            if (!with_done && k == n - 1) chk({nm, "_early_to"}, 32'(timeout_err), 32'd0);
        end
        if (with_done) begin
            chk({nm, "_wait_busy"}, 32'(busy), 32'd1);
            tx_done = 1'b1;
            step();
            tx_done = 1'b0;
            chk({nm, "_idle"}, 32'(busy), 32'd0);
            chk({nm, "_no_to"}, 32'(timeout_err), 32'd0);
        end else begin
            chk({nm, "_to_pulse"}, 32'(timeout_err), 32'd1);
            chk({nm, "_to_idle"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [1:0] m_last, m_owner, win, c;
        logic       m_lock, m_lastflag, m_idle, was_idle, found, acc;
        logic       done_pend, r_active;
        logic [3:0] exp_oh;
        logic [7:0] exp_b;
        int         r_cnt;
        item_t      it;

        tbl[0]  = '{4'b0001, 4'b1111, 32'h000000A5, 4'b0001, 2'd0, 8'hA5};
        tbl[1]  = '{4'b1111, 4'b1111, 32'h43322110, 4'b0010, 2'd1, 8'h21};
        tbl[2]  = '{4'b1111, 4'b1111, 32'h43322110, 4'b0100, 2'd2, 8'h32};
        tbl[3]  = '{4'b1111, 4'b1111, 32'h43322110, 4'b1000, 2'd3, 8'h43};
        tbl[4]  = '{4'b1111, 4'b1111, 32'h43322110, 4'b0001, 2'd0, 8'h10};
        tbl[5]  = '{4'b0110, 4'b1101, 32'h00991100, 4'b0010, 2'd1, 8'h11};
        tbl[6]  = '{4'b0110, 4'b1101, 32'h00992200, 4'b0010, 2'd1, 8'h22};
        tbl[7]  = '{4'b0110, 4'b1111, 32'h00993300, 4'b0010, 2'd1, 8'h33};
        tbl[8]  = '{4'b0110, 4'b1111, 32'h00994400, 4'b0100, 2'd2, 8'h99};
        tbl[9]  = '{4'b0010, 4'b1101, 32'h00005500, 4'b0010, 2'd1, 8'h55};
        tbl[10] = '{4'b1000, 4'b1111, 32'h66000000, 4'b1000, 2'd3, 8'h66};
        tbl[11] = '{4'b1010, 4'b1111, 32'h66007700, 4'b0010, 2'd1, 8'h77};

        rst = 1'b1; baud_tick = 1'b0; req_valid = '0; req_data = '0;
        req_last = '0; tx_done = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_to", 32'(timeout_err), 32'd0);

        // Directed vectors: single request, fairness, burst lock, lock drop.
        for (int i = 0; i < 12; i++) begin
            req_valid = tbl[i].valid;
            req_last  = tbl[i].last;
            req_data  = tbl[i].data;
            wait_accept(tbl[i].exp_oh, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_data", i), 32'(tx_data), 32'(tbl[i].exp_byte));
            chk($sformatf("vec%0d_gid", i), 32'(grant_id), 32'(tbl[i].exp_id));
            do_frame(1'b1, $sformatf("vec%0d", i));
        end

        // Watchdog: req2 frame never completes, then req0 must be served next.
        req_valid = 4'b0100; req_last = 4'b1111; req_data = 32'h00770088;
        wait_accept(4'b0100, "to_acc");
        chk("to_gid", 32'(grant_id), 32'd2);
        req_valid = 4'b0101;
        do_frame(1'b0, "to");
        chk("to_next_ready", 32'(req_ready), 32'b0001);
        wait_accept(4'b0001, "to_next");
        chk("to_pulse_once", 32'(timeout_err), 32'd0);
        chk("to_next_data", 32'(tx_data), 32'h88);
        req_valid = '0;
        do_frame(1'b1, "to_next");

        // Stray tx_done while idle is ignored.
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("stray_busy", 32'(busy), 32'd0);
        chk("stray_start", 32'(tx_start), 32'd0);
        chk("stray_to", 32'(timeout_err), 32'd0);

        // Reset mid-WAIT.
        req_valid = 4'b0010; req_data = 32'h00005A00;
        wait_accept(4'b0010, "rw_acc");
        baud_tick = 1'b1; step(); baud_tick = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(); baud_tick = 1'b1; step(); baud_tick = 1'b0;
        end
        chk("rw_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rw_start", 32'(tx_start), 32'd0);
        chk("rw_busy", 32'(busy), 32'd0);
        chk("rw_gid", 32'(grant_id), 32'd0);
        chk("rw_data", 32'(tx_data), 32'd0);
        req_valid = 4'b1111; req_data = 32'hD4C3B2A1;
        wait_accept(4'b0001, "rw_first");
        chk("rw_first_data", 32'(tx_data), 32'hA1);
        req_valid = '0;
        do_frame(1'b1, "rw_first");

        // Randomized traffic against a transaction-level model.
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_last = 2'd3; m_owner = 2'd0; m_lock = 1'b0; m_lastflag = 1'b0;
        m_idle = 1'b1; done_pend = 1'b0; r_active = 1'b0; r_cnt = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (q[i].size() == 0 && $urandom_range(0, 7) == 0) begin
                    int len;
                    len = int'($urandom_range(1, 3));
                    for (int j = 0; j < len; j++) begin
                        it.d = 8'($urandom);
                        it.l = (j == len - 1);
                        q[i].push_back(it);
                    end
                end
            end
            baud_tick = ($urandom_range(0, 2) == 0);
            tx_done   = done_pend;
            done_pend = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (q[i].size() > 0 && $urandom_range(0, 4) != 0) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = q[i][0].d;
                    req_last[i]        = q[i][0].l;
                end else begin
                    req_valid[i]       = 1'b0;
                    req_data[8*i +: 8] = 8'($urandom);
                    req_last[i]        = 1'($urandom);
                end
            end
            #1;
            exp_oh = '0; win = '0; found = 1'b0;
            was_idle = m_idle;
            if (m_idle) begin
                if (m_lock && !req_valid[m_owner]) m_lock = 1'b0;
                if (m_lock) begin
                    win = m_owner; found = 1'b1;
                end else begin
                    for (int k = 1; k <= 4; k++) begin
                        c = 2'((int'(m_last) + k) % 4);
                        if (!found && req_valid[c]) begin
                            win = c; found = 1'b1;
                        end
                    end
                end
                if (found) exp_oh[win] = 1'b1;
            end
            chk("rand_ready", 32'(req_ready), 32'(exp_oh));
            if (r_active && baud_tick) begin
                r_cnt++;
                if (r_cnt == int'(UART_FRAME_TICKS)) begin
                    done_pend = 1'b1;
                    r_active  = 1'b0;
                end
            end else if (!r_active && tx_start && baud_tick) begin
                r_active = 1'b1;
                r_cnt    = 0;
            end
            acc = found;
            if (acc) begin
                it         = q[win].pop_front();
                exp_b      = it.d;
                m_lastflag = it.l;
                m_owner    = win;
                m_idle     = 1'b0;
            end
            if (tx_done && !was_idle) begin
                m_last = m_owner;
                m_lock = !m_lastflag;
                m_idle = 1'b1;
            end
            step();
            if (acc) begin
                chk("rand_data", 32'(tx_data), 32'(exp_b));
                chk("rand_gid", 32'(grant_id), 32'(win));
                chk("rand_start", 32'(tx_start), 32'd1);
                chk("rand_busy", 32'(busy), 32'd1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
